// File: rtl/sram_bridge_par.sv
// sram_bridge_par: byte-wide asynchronous SRAM controller for the chipset bus.
//
// Each accepted request runs SETUP (address/data set up, strobe high), then WAIT_STATES
// ACCESS cycles (write strobe low, read data sampled on the last one), then DONE (ack,
// address/data hold). Requests outside the physical SRAM range take a one-cycle REJECT
// path that acks with oob and returns 8'hFF for reads.
//
// Build option: define SRAM_MIRROR_EN to ignore the upper address bits, so every address
// aliases onto the SRAM and REJECT is never entered.
//
// Ports:
//   clk_100     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   req         transfer request, sampled only when idle
//   we          1 = write, 0 = read; captured on accept
//   addr        byte address (SYS_AW bits); captured on accept
//   wdata       write data; captured on accept
//   rdata       read data; valid with ack, held until the next read completes
//   ack         one-cycle completion pulse
//   oob         one-cycle pulse alongside ack for an out-of-range access
//   sram_addr   SRAM address (SRAM_AW bits)
//   sram_dq_o   SRAM write data
//   sram_dq_oe  SRAM data pad output enable
//   sram_dq_i   SRAM read data
//   sram_we_n   SRAM write strobe, active low
//   led_act     stretched bus-activity LED, active high
//
// Parameters: SYS_AW >= SRAM_AW is required; WAIT_STATES must be at least 1.

module sram_bridge_par #(
   parameter int unsigned SYS_AW      = 21,
   parameter int unsigned SRAM_AW     = 19,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned LED_W       = 20
) (
   input  logic               clk_100,
   input  logic               reset_n,
   input  logic               req,
   input  logic               we,
   input  logic [SYS_AW-1:0]  addr,
   input  logic [7:0]         wdata,
   output logic [7:0]         rdata,
   output logic               ack,
   output logic               oob,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [7:0]         sram_dq_o,
   output logic               sram_dq_oe,
   input  logic [7:0]         sram_dq_i,
   output logic               sram_we_n,
   output logic               led_act
);

   localparam int unsigned WaitW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StAccess,
      StDone,
      StReject
   } state_e;

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic               we_q, we_d;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [7:0]         dq_o_q, dq_o_d;
   logic               dq_oe_q, dq_oe_d;
   logic               we_n_q, we_n_d;
   logic               ack_q, ack_d;
   logic               oob_q, oob_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic               in_range;

`ifdef SRAM_MIRROR_EN
   // Upper bits are deliberately dropped: addresses alias onto the physical SRAM.
   assign in_range = 1'b1;
   generate
      if (SYS_AW > SRAM_AW) begin : g_alias
         logic addr_hi_unused;
         assign addr_hi_unused = |addr[SYS_AW-1:SRAM_AW];
      end
   endgenerate
`else
   generate
      if (SYS_AW > SRAM_AW) begin : g_range
         assign in_range = (addr[SYS_AW-1:SRAM_AW] == '0);
      end else begin : g_full
         assign in_range = 1'b1;
      end
   endgenerate
`endif

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      we_d        = we_q;
      sram_addr_d = sram_addr_q;
      dq_o_d      = dq_o_q;
      dq_oe_d     = dq_oe_q;
      we_n_d      = 1'b1;
      ack_d       = 1'b0;
      oob_d       = 1'b0;
      rdata_d     = rdata_q;
      led_d       = (led_q != '0) ? (led_q - LED_W'(1)) : led_q;

      case (state_q)
         StIdle: begin
            if (req) begin
               we_d  = we;
               led_d = '1;
               if (in_range) begin
                  state_d     = StSetup;
                  sram_addr_d = addr[SRAM_AW-1:0];
                  if (we) begin
                     dq_o_d  = wdata;
                     dq_oe_d = 1'b1;
                  end
               end else begin
                  // Open bus: ack straight away, nothing reaches the SRAM pins.
                  state_d = StReject;
                  ack_d   = 1'b1;
                  oob_d   = 1'b1;
                  if (!we) begin
                     rdata_d = 8'hFF;
                  end
               end
            end
         end
         StSetup: begin
            state_d = StAccess;
            wait_d  = WaitLast;
            we_n_d  = !we_q;
         end
         StAccess: begin
            if (wait_q == '0) begin
               // Strobe rises at the end of the last ACCESS cycle; address and data
               // stay put through DONE for hold time.
               state_d = StDone;
               ack_d   = 1'b1;
               if (!we_q) begin
                  rdata_d = sram_dq_i;
               end
            end else begin
               wait_d = wait_q - WaitW'(1);
               we_n_d = !we_q;
            end
         end
         StDone: begin
            state_d = StIdle;
            dq_oe_d = 1'b0;
         end
         StReject: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Asynchronous reset releases the pads at once: strobe high, data driver off.
   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         wait_q      <= '0;
         we_q        <= 1'b0;
         sram_addr_q <= '0;
         dq_o_q      <= 8'h00;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         ack_q       <= 1'b0;
         oob_q       <= 1'b0;
         rdata_q     <= 8'h00;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         we_q        <= we_d;
         sram_addr_q <= sram_addr_d;
         dq_o_q      <= dq_o_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
         ack_q       <= ack_d;
         oob_q       <= oob_d;
         rdata_q     <= rdata_d;
         led_q       <= led_d;
      end
   end

   assign rdata      = rdata_q;
   assign ack        = ack_q;
   assign oob        = oob_q;
   assign sram_addr  = sram_addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_we_n  = we_n_q;
   assign led_act    = (led_q != '0);

endmodule

// File: tb/tb_sram_bridge_par.sv
// Testbench for sram_bridge_par: randomized and directed transfers against a behavioural
// memory model; expectations are queued at issue time and checked by a separate monitor.

module tb_sram_bridge_par;

   localparam int unsigned SYS_AW  = 21;
   localparam int unsigned SRAM_AW = 19;
   localparam int unsigned WS      = 2;
   localparam int unsigned LED_W   = 4;
   localparam int unsigned MemSize = 1 << SRAM_AW;

   logic               clk_100 = 1'b0;
   logic               reset_n = 1'b0;
   logic               req     = 1'b0;
   logic               we      = 1'b0;
   logic [SYS_AW-1:0]  addr    = '0;
   logic [7:0]         wdata   = 8'h00;
   logic [7:0]         rdata;
   logic               ack;
   logic               oob;
   logic [SRAM_AW-1:0] sram_addr;
   logic [7:0]         sram_dq_o;
   logic               sram_dq_oe;
   logic [7:0]         sram_dq_i;
   logic               sram_we_n;
   logic               led_act;

   sram_bridge_par #(
      .SYS_AW      (SYS_AW),
      .SRAM_AW     (SRAM_AW),
      .WAIT_STATES (WS),
      .LED_W       (LED_W)
   ) dut (
      .clk_100    (clk_100),
      .reset_n    (reset_n),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .ack        (ack),
      .oob        (oob),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_i  (sram_dq_i),
      .sram_we_n  (sram_we_n),
      .led_act    (led_act)
   );

   always #5 clk_100 = ~clk_100;

   int cyc = 0;
   always @(posedge clk_100) cyc <= cyc + 1;

   // External SRAM: reads are combinational, writes land while the strobe is low.
   logic [7:0] sram_mem [MemSize];
   initial for (int i = 0; i < int'(MemSize); i++) sram_mem[i] = 8'h00;
   assign sram_dq_i = sram_dq_oe ? 8'hEE : sram_mem[sram_addr];
   always @(negedge clk_100) if (reset_n && !sram_we_n) sram_mem[sram_addr] = sram_dq_o;

   // Reference model and scoreboard
   typedef struct {
      bit          we;
      int unsigned maddr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
      bit          exp_oob;
      int          exp_cyc;
   } txn_t;

   txn_t       sb[$];
   logic [7:0] ref_mem [int unsigned];
   logic [7:0] last_rd = 8'h00;
   int         n_chk = 0;
   int         n_err = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // acc is the cyc value right after the accept edge. The accept edge is cycle 0 and the
   // period following it is cycle 1, so an ack in cycle k is seen with cyc == acc + k - 1.
   task automatic predict(input bit w, input logic [SYS_AW-1:0] a, input logic [7:0] d,
                          input int acc, output txn_t t);
      bit inr;
`ifdef SRAM_MIRROR_EN
      inr = 1'b1;
`else
      inr = ((a >> SRAM_AW) == 0);
`endif
      t.we      = w;
      t.maddr   = 32'(a) % MemSize;
      t.wdata   = d;
      t.exp_oob = !inr;
      t.exp_cyc = inr ? acc + int'(WS) + 1 : acc;
      if (w) begin
         if (inr) ref_mem[t.maddr] = d;
      end else if (!inr) begin
         last_rd = 8'hFF;
      end else begin
         last_rd = ref_mem.exists(t.maddr) ? ref_mem[t.maddr] : 8'h00;
      end
      t.exp_rdata = last_rd;
   endtask

   // Monitor
   int we_run = 0;
   always @(negedge clk_100) begin
      if (!reset_n) begin
         we_run = 0;
      end else begin
         if (!sram_we_n) begin
            we_run++;
            chk("we_n_in_write", (sb.size() != 0) && sb[0].we, 1);
            if (sb.size() != 0) begin
               chk("we_addr", sram_addr, sb[0].maddr);
               chk("we_data", sram_dq_o, sb[0].wdata);
               chk("we_oe", sram_dq_oe, 1);
            end
         end else if (we_run != 0) begin
            chk("we_pulse_len", we_run, WS);
            we_run = 0;
         end
         if (sram_dq_oe) chk("oe_only_in_write", (sb.size() != 0) && sb[0].we, 1);
         chk("oob_only_with_ack", oob && !ack, 0);
         if (ack) begin : pop
            txn_t t;
            chk("ack_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               t = sb.pop_front();
               chk("ack_cycle", cyc, t.exp_cyc);
               chk("oob", oob, t.exp_oob);
               chk("rdata", rdata, t.exp_rdata);
            end
         end
      end
   end

   // Driver tasks: inputs change 1 time unit after the falling edge.
   task automatic send(input bit w, input logic [SYS_AW-1:0] a, input logic [7:0] d);
      txn_t t;
      @(negedge clk_100); #1;
      predict(w, a, d, cyc + 1, t);
      sb.push_back(t);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk_100); #1;
      req = 1'b0; we = 1'($urandom); addr = SYS_AW'($urandom); wdata = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_100); #1;
         n++;
      end
      chk("txn_timeout", sb.size(), 0);
      sb.delete();
      @(negedge clk_100); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_oob"}, oob, 0);
      chk({tag, "_rdata"}, rdata, 8'h00);
      chk({tag, "_sram_addr"}, sram_addr, 0);
      chk({tag, "_dq_o"}, sram_dq_o, 8'h00);
      chk({tag, "_dq_oe"}, sram_dq_oe, 0);
      chk({tag, "_we_n"}, sram_we_n, 1);
      chk({tag, "_led"}, led_act, 0);
   endtask

   // req held high: accepts must come exactly WS+3 cycles apart.
   task automatic held_reads(input logic [SYS_AW-1:0] a);
      txn_t t;
      int   n = 0;
      @(negedge clk_100); #1;
      for (int i = 0; i < 3; i++) begin
         predict(1'b0, a, 8'h00, cyc + 1 + i * int'(WS + 3), t);
         sb.push_back(t);
      end
      req = 1'b1; we = 1'b0; addr = a;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_100); #1;
         n++;
      end
      req = 1'b0;
      chk("held_timeout", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk_100);
   endtask

   // A read in flight while req keeps asking for a write to the same byte: dropped.
   task automatic busy_pulses(input logic [SYS_AW-1:0] a);
      txn_t t;
      @(negedge clk_100); #1;
      predict(1'b0, a, 8'h00, cyc + 1, t);
      sb.push_back(t);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk_100); #1;
      we = 1'b1; wdata = 8'h5A;
      repeat (WS + 2) @(negedge clk_100);
      #1; req = 1'b0; we = 1'b0;
      wait_idle();
   endtask

   task automatic led_test();
      txn_t t;
      int   hi = 0;
      repeat (20) @(negedge clk_100);
      #1;
      chk("led_idle", led_act, 0);
      predict(1'b0, SYS_AW'(32'h130), 8'h00, cyc + 1, t);
      sb.push_back(t);
      req = 1'b1; we = 1'b0; addr = SYS_AW'(32'h130);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_100);
         if (led_act) hi++;
         if (i == 0) begin
            #1; req = 1'b0;
         end
      end
      chk("led_on_cycles", hi, (1 << LED_W) - 1);
      wait_idle();
   endtask

   task automatic reset_abort();
      txn_t t;
      t.we = 1'b1; t.maddr = 32'h40000; t.wdata = 8'h99;
      t.exp_rdata = 8'h00; t.exp_oob = 1'b0; t.exp_cyc = 0;
      @(negedge clk_100); #1;
      sb.push_back(t);
      req = 1'b1; we = 1'b1; addr = SYS_AW'(32'h40000); wdata = 8'h99;
      @(negedge clk_100); #1;
      req = 1'b0;
      @(negedge clk_100); #1;
      chk("abort_strobe_low", sram_we_n, 0);
      reset_n = 1'b0;
      #1;
      chk("abort_we_n", sram_we_n, 1);
      chk("abort_oe", sram_dq_oe, 0);
      sb.delete();
      last_rd = 8'h00;
      repeat (3) @(negedge clk_100);
      check_reset_vals("abort_reset");
      #1; reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SYS_AW-1:0] a;
      bit                w;

      repeat (3) @(negedge clk_100);
      check_reset_vals("reset");
      #1; reset_n = 1'b1;

      send(1'b1, SYS_AW'(32'h00123), 8'hA5); wait_idle();
      send(1'b0, SYS_AW'(32'h00123), 8'h00); wait_idle();
      send(1'b1, SYS_AW'(32'h80123), 8'h3C); wait_idle();
      send(1'b0, SYS_AW'(32'h80123), 8'h00); wait_idle();
      send(1'b0, SYS_AW'(32'h00123), 8'h00); wait_idle();
      chk("sram_cell_123", sram_mem[32'h123], ref_mem[32'h123]);

      held_reads(SYS_AW'(32'h00123));
      busy_pulses(SYS_AW'(32'h00124));
      send(1'b0, SYS_AW'(32'h00124), 8'h00); wait_idle();

      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom_range(0, 1));
         a = SYS_AW'(32'h120 + $urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) a[SYS_AW-1:SRAM_AW] = 2'($urandom_range(1, 3));
         send(w, a, 8'($urandom));
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge clk_100);
      end

      led_test();
      reset_abort();
      send(1'b0, SYS_AW'(32'h00123), 8'h00); wait_idle();
      send(1'b1, SYS_AW'(32'h00125), 8'hC3); wait_idle();
      send(1'b0, SYS_AW'(32'h00125), 8'h00); wait_idle();

      repeat (4) @(negedge clk_100);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
